// File: rtl/pmem_arbiter_pkg.sv
// Shared types and widths for the physical-memory arbiter and its helpers.
//   ARB_IDLE / ARB_BUSY    : arbiter state encoding
//   LC3B_WORD_WIDTH        : byte address width
//   LC3B_C_BLOCK_WIDTH     : cache line width
//   wrap_inc()             : modulo-n increment used for round-robin start index
package pmem_arbiter_pkg;

    localparam int unsigned LC3B_WORD_WIDTH    = 16;
    localparam int unsigned LC3B_C_BLOCK_WIDTH = 128;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // idx + 1 wrapped into 0..n-1
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/pmem_arbiter_rr_pick.sv
// Combinational priority picker, reusable by other bus arbiters.
//   req_vec   : request vector, one bit per port
//   start_idx : first index searched when rr_mode=1 (ignored when rr_mode=0)
//   rr_mode   : 1 = rotating search from start_idx, 0 = lowest index wins
//   win_idx   : selected port (0 when nothing requests)
//   win_valid : at least one port requests
module rr_priority_pick #(
    parameter int unsigned NUM_PORTS = 2
) (
    input  logic [NUM_PORTS-1:0]         req_vec,
    input  logic [$clog2(NUM_PORTS)-1:0] start_idx,
    input  logic                         rr_mode,
    output logic [$clog2(NUM_PORTS)-1:0] win_idx,
    output logic                         win_valid
);

    localparam int unsigned IDX_W = $clog2(NUM_PORTS);

    // First requester found walking upward from the base, wrapping at NUM_PORTS
    always_comb begin
        int unsigned base;
        int unsigned cand;
        win_idx   = '0;
        win_valid = 1'b0;
        base      = rr_mode ? 32'(start_idx) : 32'd0;
        cand      = 0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            cand = (base + i) % NUM_PORTS;
            if (!win_valid && req_vec[cand]) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/pmem_arbiter.sv
// Shares one physical-memory port among NUM_PORTS cache-line requesters.
// The winning request is latched so memory sees stable signals until pmem_resp.
//   req_read/req_write/req_address/req_wdata : per-port level requests (flattened)
//   req_resp  : one-hot completion pulse, combinational from pmem_resp
//   req_rdata : pmem_rdata broadcast to all ports
//   pmem_*    : registered memory-side request, pmem_resp/pmem_rdata returned
//   grant_id  : current or last granted port
//   busy      : transaction outstanding (state == BUSY)
module pmem_arbiter
    import pmem_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS   = 2,
    parameter int unsigned ADDR_WIDTH  = LC3B_WORD_WIDTH,
    parameter int unsigned BLOCK_WIDTH = LC3B_C_BLOCK_WIDTH,
    parameter bit          RR_MODE     = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_PORTS-1:0]             req_read,
    input  logic [NUM_PORTS-1:0]             req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_address,
    input  logic [NUM_PORTS*BLOCK_WIDTH-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]             req_resp,
    output logic [BLOCK_WIDTH-1:0]           req_rdata,
    output logic                             pmem_read,
    output logic                             pmem_write,
    output logic [ADDR_WIDTH-1:0]            pmem_address,
    output logic [BLOCK_WIDTH-1:0]           pmem_wdata,
    input  logic                             pmem_resp,
    input  logic [BLOCK_WIDTH-1:0]           pmem_rdata,
    output logic [$clog2(NUM_PORTS)-1:0]     grant_id,
    output logic                             busy
);

    localparam int unsigned IDX_W = $clog2(NUM_PORTS);

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [IDX_W-1:0]       last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [BLOCK_WIDTH-1:0] wdata_q, wdata_d;
    logic                   rd_q, rd_d;
    logic                   wr_q, wr_d;

    logic [NUM_PORTS-1:0]   req_any;
    logic [IDX_W-1:0]       rr_start;
    logic [IDX_W-1:0]       win_idx;
    logic                   win_valid;

    assign req_any  = req_read | req_write;
    assign rr_start = IDX_W'(wrap_inc(32'(last_grant_q), NUM_PORTS));

    rr_priority_pick #(
        .NUM_PORTS (NUM_PORTS)
    ) u_pick (
        .req_vec   (req_any),
        .start_idx (rr_start),
        .rr_mode   (RR_MODE),
        .win_idx   (win_idx),
        .win_valid (win_valid)
    );

    // Next-state, latch capture and completion pulse
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        req_resp     = '0;

        case (state_q)
            ARB_IDLE: begin
                if (win_valid) begin
                    state_d      = ARB_BUSY;
                    grant_d      = win_idx;
                    last_grant_d = win_idx;
                    addr_d       = req_address[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d      = req_wdata[win_idx*BLOCK_WIDTH +: BLOCK_WIDTH];
                    // Read+write together is a requester fault: the write wins
                    wr_d         = req_write[win_idx];
                    rd_d         = req_read[win_idx] & ~req_write[win_idx];
                end
            end
            ARB_BUSY: begin
                if (pmem_resp) begin
                    req_resp[grant_q] = 1'b1;
                    state_d           = ARB_IDLE;
                    rd_d              = 1'b0;
                    wr_d              = 1'b0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase
    end

    // State and latch registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_PORTS - 1);
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
        end
    end

    assign req_rdata    = pmem_rdata;
    assign pmem_read    = rd_q;
    assign pmem_write   = wr_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;
    assign grant_id     = grant_q;
    assign busy         = (state_q == ARB_BUSY);

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: a 4-port round-robin instance (a_*) and a 4-port
// fixed-priority instance (b_*). Expected grants are queued when requests are
// driven and popped when the memory side of the arbiter shows a transaction.
`timescale 1ns/1ps
module tb_pmem_arbiter;

    localparam int unsigned NP = 4;
    localparam int unsigned AW = 16;
    localparam int unsigned BW = 128;

    typedef struct {
        int             port;
        bit             wr;
        logic [AW-1:0]  addr;
        logic [BW-1:0]  wdata;
    } exp_t;

    exp_t sb_q[$];

    logic clk;
    logic rst_n;

    logic [NP-1:0]    a_req_read, a_req_write, a_req_resp;
    logic [NP*AW-1:0] a_req_address;
    logic [NP*BW-1:0] a_req_wdata;
    logic [BW-1:0]    a_req_rdata, a_pmem_wdata, a_pmem_rdata;
    logic             a_pmem_read, a_pmem_write, a_pmem_resp, a_busy;
    logic [AW-1:0]    a_pmem_address;
    logic [1:0]       a_grant_id;

    logic [NP-1:0]    b_req_read, b_req_write, b_req_resp;
    logic [NP*AW-1:0] b_req_address;
    logic [NP*BW-1:0] b_req_wdata;
    logic [BW-1:0]    b_req_rdata, b_pmem_wdata, b_pmem_rdata;
    logic             b_pmem_read, b_pmem_write, b_pmem_resp, b_busy;
    logic [AW-1:0]    b_pmem_address;
    logic [1:0]       b_grant_id;

    int n_checks;
    int n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pmem_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .BLOCK_WIDTH(BW), .RR_MODE(1'b1)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .req_read(a_req_read), .req_write(a_req_write),
        .req_address(a_req_address), .req_wdata(a_req_wdata),
        .req_resp(a_req_resp), .req_rdata(a_req_rdata),
        .pmem_read(a_pmem_read), .pmem_write(a_pmem_write),
        .pmem_address(a_pmem_address), .pmem_wdata(a_pmem_wdata),
        .pmem_resp(a_pmem_resp), .pmem_rdata(a_pmem_rdata),
        .grant_id(a_grant_id), .busy(a_busy)
    );

    pmem_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .BLOCK_WIDTH(BW), .RR_MODE(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req_read(b_req_read), .req_write(b_req_write),
        .req_address(b_req_address), .req_wdata(b_req_wdata),
        .req_resp(b_req_resp), .req_rdata(b_req_rdata),
        .pmem_read(b_pmem_read), .pmem_write(b_pmem_write),
        .pmem_address(b_pmem_address), .pmem_wdata(b_pmem_wdata),
        .pmem_resp(b_pmem_resp), .pmem_rdata(b_pmem_rdata),
        .grant_id(b_grant_id), .busy(b_busy)
    );

    task automatic clear_inputs();
        a_req_read = '0; a_req_write = '0; a_req_address = '0; a_req_wdata = '0;
        a_pmem_resp = 1'b0; a_pmem_rdata = '0;
        b_req_read = '0; b_req_write = '0; b_req_address = '0; b_req_wdata = '0;
        b_pmem_resp = 1'b0; b_pmem_rdata = '0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Waits for a memory-side request on the selected instance; cyc = -1 on timeout.
    // Returns positioned at a falling edge.
    task automatic wait_op(input bit sel_b, output int cyc);
        bit found;
        found = 1'b0;
        cyc   = -1;
        for (int k = 1; k <= 20; k++) begin
            if (!found) begin
                @(posedge clk);
                @(negedge clk);
                if (sel_b ? (b_pmem_read | b_pmem_write) : (a_pmem_read | a_pmem_write)) begin
                    found = 1'b1;
                    cyc   = k;
                end
            end
        end
    endtask

    task automatic test_reset();
        int cyc;
        @(negedge clk);
        n_checks++;
        if (a_busy !== 1'b0 || a_pmem_read !== 1'b0 || a_pmem_write !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy=%b rd=%b wr=%b want 0 0 0", a_busy, a_pmem_read, a_pmem_write);
        end
        n_checks++;
        if (a_grant_id !== 2'd0 || a_pmem_address !== '0 || a_req_resp !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: grant=%0d addr=%h resp=%b want 0 0 0", a_grant_id, a_pmem_address, a_req_resp);
        end
        @(posedge clk); #1 rst_n = 1'b1;

        // Port 1 write outstanding, then reset for one cycle
        a_req_write = 4'b0010;
        a_req_address[1*AW +: AW] = 16'h0ABC;
        a_req_wdata[1*BW +: BW]   = {4{32'hDEADBEEF}};
        wait_op(1'b0, cyc);
        n_checks++;
        if (cyc < 0 || a_pmem_write !== 1'b1 || a_grant_id !== 2'd1) begin
            n_fail++;
            $display("FAIL reset_pre_write: cyc=%0d wr=%b grant=%0d want wr=1 grant=1", cyc, a_pmem_write, a_grant_id);
        end
        @(posedge clk); #1;
        a_req_write = '0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (a_pmem_write !== 1'b0 || a_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_busy: wr=%b busy=%b want 0 0", a_pmem_write, a_busy);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        a_pmem_resp = 1'b1;
        @(negedge clk);
        n_checks++;
        if (a_req_resp !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_stale_resp: req_resp=%b want 0000", a_req_resp);
        end
        @(posedge clk); #1 a_pmem_resp = 1'b0;
        @(negedge clk);
        n_checks++;
        if (a_busy !== 1'b0 || a_pmem_write !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_after_resp: busy=%b wr=%b want 0 0", a_busy, a_pmem_write);
        end
    endtask

    task automatic test_single_read();
        int cyc;
        exp_t e;
        logic [BW-1:0] rd;
        @(posedge clk); #1;
        a_req_read = 4'b0001;
        a_req_address[0 +: AW] = 16'h1230;
        sb_q.push_back('{port: 0, wr: 1'b0, addr: 16'h1230, wdata: '0});
        @(negedge clk);
        n_checks++;
        if (a_pmem_read !== 1'b0 || a_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early: rd=%b busy=%b want 0 0 in request cycle", a_pmem_read, a_busy);
        end
        wait_op(1'b0, cyc);
        e = sb_q.pop_front();
        n_checks++;
        if (cyc !== 1 || a_pmem_read !== 1'b1 || a_pmem_write !== 1'b0 ||
            a_pmem_address !== e.addr || 32'(a_grant_id) !== e.port) begin
            n_fail++;
            $display("FAIL single_grant: cyc=%0d rd=%b wr=%b addr=%h grant=%0d want 1 1 0 %h %0d",
                     cyc, a_pmem_read, a_pmem_write, a_pmem_address, a_grant_id, e.addr, e.port);
        end
        repeat (3) @(posedge clk);
        #1;
        rd = {$urandom, $urandom, $urandom, $urandom};
        a_pmem_resp  = 1'b1;
        a_pmem_rdata = rd;
        @(negedge clk);
        n_checks++;
        if (a_req_resp !== 4'b0001 || a_req_rdata !== rd || a_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_resp: resp=%b rdata=%h busy=%b want 0001 %h 1", a_req_resp, a_req_rdata, a_busy, rd);
        end
        @(posedge clk); #1;
        a_pmem_resp = 1'b0;
        a_req_read  = '0;
        @(negedge clk);
        n_checks++;
        if (a_busy !== 1'b0 || a_req_resp !== 4'b0000 || a_pmem_read !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: busy=%b resp=%b rd=%b want 0 0000 0", a_busy, a_req_resp, a_pmem_read);
        end
    endtask

    task automatic test_rr_order();
        int cyc;
        exp_t e;
        logic [NP-1:0] exp_resp;
        do_reset();
        for (int i = 0; i < int'(NP); i++) begin
            a_req_address[i*AW +: AW] = AW'(16'h0100 * (i + 1));
        end
        a_req_read = 4'hF;
        for (int n = 0; n < 5; n++) begin
            sb_q.push_back('{port: n % 4, wr: 1'b0, addr: AW'(16'h0100 * ((n % 4) + 1)), wdata: '0});
        end
        for (int n = 0; n < 5; n++) begin
            wait_op(1'b0, cyc);
            e = sb_q.pop_front();
            n_checks++;
            if (cyc !== 1 || 32'(a_grant_id) !== e.port || a_pmem_address !== e.addr || a_pmem_read !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: cyc=%0d grant=%0d addr=%h rd=%b want 1 %0d %h 1",
                         n, cyc, a_grant_id, a_pmem_address, a_pmem_read, e.port, e.addr);
            end
            @(posedge clk); #1 a_pmem_resp = 1'b1;
            exp_resp = '0;
            exp_resp[e.port] = 1'b1;
            @(negedge clk);
            n_checks++;
            if (a_req_resp !== exp_resp) begin
                n_fail++;
                $display("FAIL rr_resp[%0d]: resp=%b want %b", n, a_req_resp, exp_resp);
            end
            @(posedge clk); #1;
            a_pmem_resp = 1'b0;
            if (n == 4) a_req_read = '0;
            @(negedge clk);
            n_checks++;
            if (a_busy !== 1'b0 || a_pmem_read !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_bubble[%0d]: busy=%b rd=%b want 0 0", n, a_busy, a_pmem_read);
            end
        end
    endtask

    task automatic test_fixed_priority();
        int cyc;
        exp_t e;
        logic [NP-1:0] exp_resp;
        @(posedge clk); #1;
        b_req_address[0*AW +: AW] = 16'h2000;
        b_req_address[2*AW +: AW] = 16'h2200;
        b_req_read = 4'b0101;
        sb_q.push_back('{port: 0, wr: 1'b0, addr: 16'h2000, wdata: '0});
        sb_q.push_back('{port: 0, wr: 1'b0, addr: 16'h2000, wdata: '0});
        sb_q.push_back('{port: 0, wr: 1'b0, addr: 16'h2000, wdata: '0});
        sb_q.push_back('{port: 2, wr: 1'b0, addr: 16'h2200, wdata: '0});
        for (int n = 0; n < 4; n++) begin
            wait_op(1'b1, cyc);
            e = sb_q.pop_front();
            n_checks++;
            if (cyc !== 1 || 32'(b_grant_id) !== e.port || b_pmem_address !== e.addr) begin
                n_fail++;
                $display("FAIL fp_grant[%0d]: cyc=%0d grant=%0d addr=%h want 1 %0d %h",
                         n, cyc, b_grant_id, b_pmem_address, e.port, e.addr);
            end
            @(posedge clk); #1 b_pmem_resp = 1'b1;
            exp_resp = '0;
            exp_resp[e.port] = 1'b1;
            @(negedge clk);
            n_checks++;
            if (b_req_resp !== exp_resp) begin
                n_fail++;
                $display("FAIL fp_resp[%0d]: resp=%b want %b", n, b_req_resp, exp_resp);
            end
            @(posedge clk); #1;
            b_pmem_resp = 1'b0;
            if (n == 2) b_req_read[0] = 1'b0;
            if (n == 3) b_req_read = '0;
        end
    endtask

    task automatic test_addr_hold();
        int cyc;
        exp_t e;
        @(posedge clk); #1;
        a_req_address[1*AW +: AW] = 16'h0040;
        a_req_read = 4'b0010;
        sb_q.push_back('{port: 1, wr: 1'b0, addr: 16'h0040, wdata: '0});
        wait_op(1'b0, cyc);
        e = sb_q.pop_front();
        n_checks++;
        if (cyc < 0 || 32'(a_grant_id) !== e.port || a_pmem_address !== e.addr) begin
            n_fail++;
            $display("FAIL hold_grant: cyc=%0d grant=%0d addr=%h want %0d %h", cyc, a_grant_id, a_pmem_address, e.port, e.addr);
        end
        @(posedge clk); #1 a_req_address[1*AW +: AW] = 16'h0080;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (a_pmem_address !== e.addr) begin
                n_fail++;
                $display("FAIL hold_addr[%0d]: addr=%h want %h", k, a_pmem_address, e.addr);
            end
            @(posedge clk); #1;
        end
        a_pmem_resp = 1'b1;
        @(negedge clk);
        n_checks++;
        if (a_req_resp !== 4'b0010 || a_pmem_address !== e.addr) begin
            n_fail++;
            $display("FAIL hold_resp: resp=%b addr=%h want 0010 %h", a_req_resp, a_pmem_address, e.addr);
        end
        @(posedge clk); #1;
        a_pmem_resp = 1'b0;
        a_req_read  = '0;
        @(negedge clk);
    endtask

    task automatic test_rw_conflict();
        int cyc;
        exp_t e;
        @(posedge clk); #1;
        a_req_wdata[0 +: BW] = {16{8'hA5}};
        a_req_address[0 +: AW] = 16'h3000;
        a_req_read  = 4'b0001;
        a_req_write = 4'b0001;
        sb_q.push_back('{port: 0, wr: 1'b1, addr: 16'h3000, wdata: {16{8'hA5}}});
        wait_op(1'b0, cyc);
        e = sb_q.pop_front();
        n_checks++;
        if (cyc < 0 || a_pmem_write !== e.wr || a_pmem_read !== 1'b0 ||
            a_pmem_wdata !== e.wdata || 32'(a_grant_id) !== e.port) begin
            n_fail++;
            $display("FAIL rw_grant: wr=%b rd=%b wdata=%h grant=%0d want 1 0 %h %0d",
                     a_pmem_write, a_pmem_read, a_pmem_wdata, a_grant_id, e.wdata, e.port);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++;
            if (a_pmem_read !== 1'b0 || a_pmem_write !== 1'b1) begin
                n_fail++;
                $display("FAIL rw_hold[%0d]: rd=%b wr=%b want 0 1", k, a_pmem_read, a_pmem_write);
            end
        end
        @(posedge clk); #1 a_pmem_resp = 1'b1;
        @(negedge clk);
        n_checks++;
        if (a_req_resp !== 4'b0001) begin
            n_fail++;
            $display("FAIL rw_resp: resp=%b want 0001", a_req_resp);
        end
        @(posedge clk); #1;
        a_pmem_resp = 1'b0;
        a_req_read  = '0;
        a_req_write = '0;
        @(negedge clk);
        n_checks++;
        if (a_busy !== 1'b0 || a_pmem_write !== 1'b0) begin
            n_fail++;
            $display("FAIL rw_done: busy=%b wr=%b want 0 0", a_busy, a_pmem_write);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        clear_inputs();
        test_reset();
        test_single_read();
        test_rr_order();
        test_fixed_priority();
        test_addr_hold();
        test_rw_conflict();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: %0d entries want 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
